// File: rtl/melody_player_57_if.sv
// Bundles the control, beat/tone inputs and the sound/status outputs
// of melody_player_57; the player takes the slave side.
interface melody_player_57_if;
    logic       start_57;
    logic       stop_57;
    logic       beat_57;
    logic [7:0] tone_57;
    logic       buzzer_57;
    logic       busy_57;
    logic [2:0] note_idx_57;
    logic       done_57;

    modport master (
        output start_57, stop_57, beat_57, tone_57,
        input  buzzer_57, busy_57, note_idx_57, done_57
    );

    modport slave (
        input  start_57, stop_57, beat_57, tone_57,
        output buzzer_57, busy_57, note_idx_57, done_57
    );
endinterface

// File: rtl/melody_player_57.sv
// Beat-timed 16-step scale sequencer: gates one of eight divider tones onto
// the buzzer per beat, playing REPEATS passes separated by a one-beat rest.
module melody_player_57 #(
    parameter int unsigned REPEATS = 2
) (
    input  logic                      clk_50m_57,
    input  logic                      rst_57,
    melody_player_57_if.slave         bus
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_PLAY, S_GAP} state_e;

    localparam logic [3:0] LAST_REP  = 4'(REPEATS - 1);
    localparam logic [3:0] LAST_STEP = 4'd15;
    localparam logic [2:0] ROM [16] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                                        3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    state_e     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [3:0] rep_q, rep_d;
    logic       start_dly_q, beat_dly_q;
    logic       buzzer_q, buzzer_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] note_q, note_d;
    logic       start_rise, beat_rise, finish;

    assign start_rise = bus.start_57 & ~start_dly_q;
    assign beat_rise  = bus.beat_57  & ~beat_dly_q;

    // NOTE: every flop below uses <= so all of them update from the same
    // pre-edge values; blocking here would let later lines see new state.
    always_ff @(posedge clk_50m_57 or posedge rst_57) begin
        if (rst_57) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            rep_q       <= '0;
            start_dly_q <= 1'b0;
            beat_dly_q  <= 1'b0;
            buzzer_q    <= 1'b0;
            busy_q      <= 1'b0;
            note_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            rep_q       <= rep_d;
            start_dly_q <= bus.start_57;
            beat_dly_q  <= bus.beat_57;
            buzzer_q    <= buzzer_d;
            busy_q      <= busy_d;
            note_q      <= note_d;
            done_q      <= done_d;
        end
    end

    // NOTE: defaults first so every path assigns every signal and no latch
    // is inferred when a branch leaves a signal untouched.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        rep_d   = rep_q;
        finish  = 1'b0;
        if (state_q != S_IDLE && bus.stop_57) begin
            state_d = S_IDLE;
            step_d  = '0;
            rep_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: if (start_rise && !bus.stop_57) begin
                    state_d = S_ARM;
                    step_d  = '0;
                    rep_d   = '0;
                end
                S_ARM: if (beat_rise) begin
                    state_d = S_PLAY;
                    step_d  = '0;
                end
                S_PLAY: if (beat_rise) begin
                    step_d = step_q + 4'd1;
                    if (step_q == LAST_STEP) begin
                        if (rep_q == LAST_REP) begin
                            state_d = S_IDLE;
                            finish  = 1'b1;
                            rep_d   = '0;
                        end else begin
                            state_d = S_GAP;
                            rep_d   = rep_q + 4'd1;
                        end
                    end
                end
                S_GAP: if (beat_rise) begin
                    state_d = S_PLAY;
                    step_d  = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are computed from the next state so they appear one cycle
    // after the deciding input, together with the state change.
    always_comb begin
        buzzer_d = 1'b0;
        note_d   = '0;
        busy_d   = (state_d != S_IDLE);
        done_d   = finish;
        if (state_d == S_PLAY) begin
            note_d   = ROM[step_d];
            buzzer_d = bus.tone_57[note_d];
        end
    end

    assign bus.buzzer_57   = buzzer_q;
    assign bus.busy_57     = busy_q;
    assign bus.note_idx_57 = note_q;
    assign bus.done_57     = done_q;
endmodule

// File: tb/tb_melody_player_57.sv
// Drives a REPEATS=1 and a REPEATS=2 player with identical stimulus and
// checks both against per-beat expectations queued as each beat is driven.
module tb_melody_player_57;
    typedef struct packed {
        logic [2:0] note;
        logic       busy;
        logic       done;
        logic       sound;
    } exp_t;

    localparam exp_t IDLE_E = '{note: 3'd0, busy: 1'b0, done: 1'b0, sound: 1'b0};
    localparam exp_t ARM_E  = '{note: 3'd0, busy: 1'b1, done: 1'b0, sound: 1'b0};
    localparam exp_t DONE_E = '{note: 3'd0, busy: 1'b0, done: 1'b1, sound: 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_in = 1'b0;
    logic       stop_in = 1'b0;
    logic       beat_in = 1'b0;
    logic [7:0] tone_in = 8'h00;
    logic [7:0] tone_prev = 8'h00;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t cur_a, cur_b;
    exp_t q_a[$];
    exp_t q_b[$];

    melody_player_57_if if_a ();
    melody_player_57_if if_b ();

    assign if_a.start_57 = start_in;
    assign if_a.stop_57  = stop_in;
    assign if_a.beat_57  = beat_in;
    assign if_a.tone_57  = tone_in;
    assign if_b.start_57 = start_in;
    assign if_b.stop_57  = stop_in;
    assign if_b.beat_57  = beat_in;
    assign if_b.tone_57  = tone_in;

    melody_player_57 #(.REPEATS(1)) u_dut_a (.clk_50m_57(clk), .rst_57(rst), .bus(if_a));
    melody_player_57 #(.REPEATS(2)) u_dut_b (.clk_50m_57(clk), .rst_57(rst), .bus(if_b));

    always #5 clk = ~clk;

    function automatic exp_t play_e(input int step);
        exp_t e;
        e.note  = 3'((step < 8) ? step : 15 - step);
        e.busy  = 1'b1;
        e.done  = 1'b0;
        e.sound = 1'b1;
        return e;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string who, input logic buz, input logic bsy,
                            input logic [2:0] ni, input logic dn, input exp_t e);
        logic exp_buz;
        exp_buz = e.sound ? tone_prev[e.note] : 1'b0;
        check({who, ".buzzer"},   8'(buz), 8'(exp_buz));
        check({who, ".busy"},     8'(bsy), 8'(e.busy));
        check({who, ".note_idx"}, 8'(ni),  8'(e.note));
        check({who, ".done"},     8'(dn),  8'(e.done));
    endtask

    // One clock: sample just after the edge, compare, then drive a new tone.
    task automatic tick(input bit load);
        tone_prev = tone_in;
        @(posedge clk);
        #1;
        if (load) begin
            if (q_a.size() == 0 || q_b.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard: queue empty, required an entry");
            end else begin
                cur_a = q_a.pop_front();
                cur_b = q_b.pop_front();
            end
        end
        chk_outs("A", if_a.buzzer_57, if_a.busy_57, if_a.note_idx_57, if_a.done_57, cur_a);
        chk_outs("B", if_b.buzzer_57, if_b.busy_57, if_b.note_idx_57, if_b.done_57, cur_b);
        cur_a.done = 1'b0;
        cur_b.done = 1'b0;
        tone_in = 8'($urandom);
    endtask

    task automatic drive_tick(input exp_t ea, input exp_t eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
        tick(1'b1);
    endtask

    // One 100-cycle beat period: 50 high, 50 low.
    task automatic beat(input exp_t ea, input exp_t eb);
        beat_in = 1'b1;
        drive_tick(ea, eb);
        repeat (49) tick(1'b0);
        beat_in = 1'b0;
        repeat (50) tick(1'b0);
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        drive_tick(ARM_E, ARM_E);
        start_in = 1'b0;
        repeat (5) tick(1'b0);
    endtask

    task automatic play_melody(input bit retrig);
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            beat(play_e(i), play_e(i));
            if (retrig && i == 3) begin
                start_in = 1'b1;
                tick(1'b0);
                start_in = 1'b0;
            end
        end
        beat(DONE_E, ARM_E);
        for (int i = 0; i < 16; i++) beat(IDLE_E, play_e(i));
        beat(IDLE_E, DONE_E);
        beat(IDLE_E, IDLE_E);
    endtask

    initial begin
        cur_a = IDLE_E;
        cur_b = IDLE_E;
        #1 rst = 1'b1;
        #2;
        chk_outs("A.rst", if_a.buzzer_57, if_a.busy_57, if_a.note_idx_57, if_a.done_57, IDLE_E);
        chk_outs("B.rst", if_b.buzzer_57, if_b.busy_57, if_b.note_idx_57, if_b.done_57, IDLE_E);
        repeat (3) tick(1'b0);
        rst = 1'b0;
        repeat (3) tick(1'b0);

        play_melody(1'b0);
        play_melody(1'b1);

        pulse_start();
        for (int i = 0; i < 6; i++) beat(play_e(i), play_e(i));
        stop_in = 1'b1;
        drive_tick(IDLE_E, IDLE_E);
        stop_in = 1'b0;
        repeat (3) tick(1'b0);
        beat(IDLE_E, IDLE_E);
        pulse_start();
        for (int i = 0; i < 3; i++) beat(play_e(i), play_e(i));
        stop_in = 1'b1;
        drive_tick(IDLE_E, IDLE_E);
        stop_in = 1'b0;
        repeat (3) tick(1'b0);

        start_in = 1'b1;
        stop_in  = 1'b1;
        drive_tick(IDLE_E, IDLE_E);
        start_in = 1'b0;
        stop_in  = 1'b0;
        repeat (4) tick(1'b0);

        pulse_start();
        for (int i = 0; i < 10; i++) beat(play_e(i), play_e(i));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_outs("A.arst", if_a.buzzer_57, if_a.busy_57, if_a.note_idx_57, if_a.done_57, IDLE_E);
        chk_outs("B.arst", if_b.buzzer_57, if_b.busy_57, if_b.note_idx_57, if_b.done_57, IDLE_E);
        cur_a = IDLE_E;
        cur_b = IDLE_E;
        repeat (3) tick(1'b0);
        beat_in = 1'b1;
        rst = 1'b0;
        repeat (20) tick(1'b0);
        beat_in = 1'b0;
        repeat (20) tick(1'b0);
        beat(IDLE_E, IDLE_E);
        beat(IDLE_E, IDLE_E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/melody_player_57.md
# melody_player_57

Beat-timed melody sequencer that sits directly downstream of the 50 MHz frequency divider. It consumes the divider's 2 Hz beat square wave and the eight note square waves (523–1047 Hz). On request it gates those tones onto a single buzzer output as a fixed 16-step scale melody, repeated a configurable number of times, with a one-beat rest between repeats. Typical uses are the hourly chime and the alarm sound of the digital clock.

## Interface
- REPEATS, default 2: number of melody passes per start; legal range 1..15.
- clk_50m_57  in  1  system clock, 50 MHz; the only clock.
- rst_57  in  1  reset, asynchronous, active-high.
- start_57  in  1  play request; only its rising edge, detected in the clk_50m_57 domain, counts.
- stop_57  in  1  abort, level-sensitive.
- beat_57  in  1  2 Hz square wave from the divider; each rising edge is one beat.
- tone_57  in  8  note square waves from the divider: bit0=523, bit1=587, bit2=659, bit3=698, bit4=784, bit5=880, bit6=988, bit7=1047 Hz.
- buzzer_57  out  1  gated tone to the piezo driver.
- busy_57  out  1  high in every state except IDLE.
- note_idx_57  out  3  current note code while in PLAY; 0 otherwise.
- done_57  out  1  one-cycle pulse on normal completion.

## Operation
- All inputs come from registers clocked by clk_50m_57, so no synchronizers are used.
  - Edge detect: start_d and beat_d registers.
  - start_rise = start_57 & ~start_d.
  - beat_rise = beat_57 & ~beat_d.
- Melody ROM, 16 steps, note codes in order: 0,1,2,3,4,5,6,7,7,6,5,4,3,2,1,0.
- step counter is 4 bits and wraps 15→0. rep counter is 4 bits.
- FSM states:
  - IDLE: busy=0, buzzer=0. On start_rise with stop_57=0: go to ARM, clear step and rep.
  - ARM: wait for beat alignment. On beat_rise: go to PLAY with step=0.
  - PLAY: buzzer_57 = tone_57[rom[step]]; note_idx_57 = rom[step].
    - On beat_rise with step<15: step+1.
    - On beat_rise with step=15 and rep<REPEATS-1: go to GAP, rep+1, step wraps to 0.
    - On beat_rise with step=15 and rep=REPEATS-1: go to IDLE and assert done_57 for one cycle.
  - GAP: buzzer=0, note_idx=0. On beat_rise: go to PLAY with step=0.
- stop_57=1 in any state other than IDLE: go to IDLE on the next edge. buzzer drops to 0, done_57 is not asserted, and step and rep are cleared.
- Priority: stop_57 over beat_rise over start_rise.
- start_rise in any state other than IDLE is ignored and does not restart the melody.
- start_rise and stop_57 in the same IDLE cycle: stay in IDLE.

## Timing
- Reset values:
  - state IDLE, step 0, rep 0, start_d 0, beat_d 0.
  - buzzer_57, busy_57, note_idx_57 and done_57 all 0.
- Because beat_d resets to 0, a beat_57 that is high at reset release counts as a beat_rise in the first cycle. This is harmless outside ARM.
- All outputs are registered, so each output reflects its state one clk_50m_57 cycle after the state change.
- buzzer_57 follows tone_57 with exactly 1 cycle of latency while in PLAY.
- Latency to sound:
  - The start_rise cycle is cycle 0; busy_57=1 at cycle 1.
  - The first note sounds 1 cycle after the first beat_rise seen in ARM.
  - Worst case is 0.5 s + 2 cycles.
- Each step lasts exactly one beat period, 25,000,000 cycles at 2 Hz.
- One pass takes 16 beats and each GAP takes 1 beat. The default total is 33 beats, counted from the first beat in ARM to done_57.
- done_57 is asserted in the same cycle that busy_57 falls.
- Reset asserted mid-play: outputs go to 0 asynchronously. After release the block stays in IDLE until a new start_rise.

## Test plan
- Basic play, REPEATS=1, beat driven every 100 cycles:
  - Pulse start_57, then apply 17 beat edges.
  - Required: note_idx_57 steps through 0..7,7..0; buzzer_57 equals tone_57[code] delayed 1 cycle; done_57 is one cycle wide on the 17th beat edge (the edge that ends step 15); busy_57=0 after it.
- Repeat and gap, REPEATS=2:
  - Required: after step 15, one beat with buzzer_57=0 and note_idx_57=0 (GAP), then a second pass, then a single done_57 pulse.
  - Required: exactly 33 beat edges are consumed after the ARM edge.
- Abort:
  - Assert stop_57 during step 5.
  - Required: next cycle busy_57=0, buzzer_57=0, done_57 stays 0; a later start_rise plays from step 0.
- Retrigger ignored:
  - Pulse start_57 again during step 3.
  - Required: step sequence unaffected; only one done_57 pulse.
- Simultaneous events: in IDLE, raise start_57 and stop_57 in the same cycle.
  - Required: busy_57 stays 0.
- Async reset mid-play:
  - Assert rst_57 between clock edges during step 9.
  - Required: all outputs 0 immediately, before the next edge; after release, beats alone do not start play.
